ppu_timing: RTL and testbench

- Consumes the PPU/CPU tick strobes produced by the master clock generator and owns NES PPU raster timing.
- Tracks dot (0..340) and scanline (0..261) and holds the vblank status flag, including the $2002 read-clear and read/set race.
- Drives the /NMI line to the CPU.
- Sits between the clock generator and the PPU render pipeline / register file; all logic runs on m_clk, gated by tick enables.

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/ppu_timing_if.sv | 30 +++
 rtl/ppu_raster_counter.sv | 82 ++++++++
 rtl/ppu_timing.sv | 81 ++++++++
 tb/tb_ppu_timing.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared NES PPU raster timing constants and types.
// Build option: PPU_TIMING_PAL_EN selects the 312-line PAL frame as the
// default pre-render line.
package ppu_pkg;

  localparam int NTSC_LAST_DOT = 340;
  localparam int NTSC_PRE_LINE = 261;
  localparam int PAL_PRE_LINE  = 311;
  localparam int VBLANK_LINE   = 241;
  localparam int VISIBLE_LINES = 240;
  localparam int VISIBLE_DOTS  = 256;

  localparam int DOT_W  = 9;
  localparam int LINE_W = 9;

`ifdef PPU_TIMING_PAL_EN
  localparam int DEF_PRE_LINE = PAL_PRE_LINE;
`else
  localparam int DEF_PRE_LINE = NTSC_PRE_LINE;
`endif

  typedef logic [DOT_W-1:0]  dot_t;
  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/ppu_timing_if.sv
// Tick/control inputs and raster/status outputs of the PPU timing block.
// master = clock generator / register file side, slave = ppu_timing.
interface ppu_timing_if;
  import ppu_pkg::*;

  logic  ppu_tick;
  logic  cpu_tick;
  logic  render_en;
  logic  nmi_en;
  logic  status_rd;
  dot_t  dot;
  line_t scanline;
  logic  visible;
  logic  vblank;
  logic  status_vblank;
  logic  nmi_n;
  logic  frame_odd;
  logic  frame_start;

  modport master (
    output ppu_tick, cpu_tick, render_en, nmi_en, status_rd,
    input  dot, scanline, visible, vblank, status_vblank, nmi_n, frame_odd, frame_start
  );

  modport slave (
    input  ppu_tick, cpu_tick, render_en, nmi_en, status_rd,
    output dot, scanline, visible, vblank, status_vblank, nmi_n, frame_odd, frame_start
  );

endinterface

// File: rtl/ppu_raster_counter.sv
// Dot/scanline raster counters with frame wrap and NTSC odd-frame short line.
// Build option: PPU_TIMING_PAL_EN removes the odd-frame dot skip.
module ppu_raster_counter import ppu_pkg::*; #(
  parameter int LAST_DOT      = NTSC_LAST_DOT,
  parameter int PRE_LINE      = DEF_PRE_LINE,
  parameter int VISIBLE_LINES = ppu_pkg::VISIBLE_LINES,
  parameter int VISIBLE_DOTS  = ppu_pkg::VISIBLE_DOTS
) (
  input  logic  m_clk,
  input  logic  rst_n,
  input  logic  ppu_tick_i,
  input  logic  render_en_i,
  output dot_t  dot_o,
  output line_t scanline_o,
  output logic  visible_o,
  output logic  frame_odd_o,
  output logic  frame_start_o
);

  dot_t  dot_q, dot_d;
  line_t line_q, line_d;
  logic  odd_q, odd_d;
  logic  fs_q, fs_d;
  logic  vis_q, vis_d;
  logic  skip, dot_wrap, line_wrap;

  // Next raster position on a dot tick; visible is derived from the new position.
  always_comb begin
`ifdef PPU_TIMING_PAL_EN
    skip = 1'b0;
`else
    skip = (line_q == line_t'(PRE_LINE)) && (dot_q == dot_t'(LAST_DOT - 1)) &&
           odd_q && render_en_i;
`endif
    dot_wrap  = (dot_q == dot_t'(LAST_DOT)) || skip;
    line_wrap = dot_wrap && (line_q == line_t'(PRE_LINE));
    dot_d  = dot_q;
    line_d = line_q;
    odd_d  = odd_q;
    fs_d   = 1'b0;
    if (ppu_tick_i) begin
      if (dot_wrap) begin
        dot_d = '0;
        if (line_wrap) begin
          line_d = '0;
          odd_d  = ~odd_q;
          fs_d   = 1'b1;
        end else begin
          line_d = line_q + line_t'(1);
        end
      end else begin
        dot_d = dot_q + dot_t'(1);
      end
    end
    vis_d = (line_d < line_t'(VISIBLE_LINES)) && (dot_d >= dot_t'(1)) &&
            (dot_d <= dot_t'(VISIBLE_DOTS));
  end

  // Raster state register.
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q  <= '0;
      line_q <= '0;
      odd_q  <= 1'b0;
      fs_q   <= 1'b0;
      vis_q  <= 1'b0;
    end else begin
      dot_q  <= dot_d;
      line_q <= line_d;
      odd_q  <= odd_d;
      fs_q   <= fs_d;
      vis_q  <= vis_d;
    end
  end

  assign dot_o         = dot_q;
  assign scanline_o    = line_q;
  assign visible_o     = vis_q;
  assign frame_odd_o   = odd_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/ppu_timing.sv
// NES PPU raster timing: raster counters, vblank flag with $2002 read-clear
// and read/set race suppression, and the registered /NMI output.
// Build option: PPU_TIMING_PAL_EN (312-line frame, no odd-frame skip).
module ppu_timing import ppu_pkg::*; #(
  parameter int LAST_DOT      = NTSC_LAST_DOT,
  parameter int VBLANK_LINE   = ppu_pkg::VBLANK_LINE,
  parameter int PRE_LINE      = DEF_PRE_LINE,
  parameter int VISIBLE_LINES = ppu_pkg::VISIBLE_LINES,
  parameter int VISIBLE_DOTS  = ppu_pkg::VISIBLE_DOTS
) (
  input logic          m_clk,
  input logic          rst_n,
  ppu_timing_if.slave  bus
);

  dot_t  dot;
  line_t line;
  logic  visible, frame_odd, frame_start;
  logic  rd, set_ev, clr_ev;
  logic  vblank_q, vblank_d;
  logic  stat_q, stat_d;
  logic  nmi_n_q, nmi_n_d;
  logic  rd_q;

  ppu_raster_counter #(
    .LAST_DOT      (LAST_DOT),
    .PRE_LINE      (PRE_LINE),
    .VISIBLE_LINES (VISIBLE_LINES),
    .VISIBLE_DOTS  (VISIBLE_DOTS)
  ) u_raster (
    .m_clk         (m_clk),
    .rst_n         (rst_n),
    .ppu_tick_i    (bus.ppu_tick),
    .render_en_i   (bus.render_en),
    .dot_o         (dot),
    .scanline_o    (line),
    .visible_o     (visible),
    .frame_odd_o   (frame_odd),
    .frame_start_o (frame_start)
  );

  // The set/clear points are the ticks leaving dot 0 of their line, i.e. entering dot 1.
  assign rd     = bus.cpu_tick & bus.status_rd;
  assign set_ev = bus.ppu_tick && (line == line_t'(VBLANK_LINE)) && (dot == '0);
  assign clr_ev = bus.ppu_tick && (line == line_t'(PRE_LINE)) && (dot == '0);

  // vblank set/clear with race suppression, read-back value and NMI level.
  always_comb begin
    vblank_d = vblank_q;
    stat_d   = stat_q;
    if (set_ev && !(rd || rd_q)) vblank_d = 1'b1;
    if (clr_ev || rd)            vblank_d = 1'b0;
    if (rd)                      stat_d   = vblank_q & ~set_ev;
    nmi_n_d = ~(vblank_q & bus.nmi_en);
  end

  // Status/NMI registers; rd_q remembers a read on the previous m_clk for the race window.
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
      stat_q   <= 1'b0;
      nmi_n_q  <= 1'b1;
      rd_q     <= 1'b0;
    end else begin
      vblank_q <= vblank_d;
      stat_q   <= stat_d;
      nmi_n_q  <= nmi_n_d;
      rd_q     <= rd;
    end
  end

  assign bus.dot           = dot;
  assign bus.scanline      = line;
  assign bus.visible       = visible;
  assign bus.frame_odd     = frame_odd;
  assign bus.frame_start   = frame_start;
  assign bus.vblank        = vblank_q;
  assign bus.status_vblank = stat_q;
  assign bus.nmi_n         = nmi_n_q;

endmodule

// File: tb/tb_ppu_timing.sv
// Bench for ppu_timing. A shrunken-raster instance exercises frame, skip,
// vblank, race and reset behaviour against a tick-count model; a default
// instance free-runs to check the real dot/line/visible geometry.
module tb_ppu_timing;
  import ppu_pkg::*;

  localparam int S_LAST = 20;
  localparam int S_VB   = 7;
  localparam int S_PRE  = 10;
  localparam int S_VL   = 6;
  localparam int S_VD   = 16;
  localparam int W      = S_LAST + 1;
  localparam int N      = W * (S_PRE + 1);
  localparam int FW     = NTSC_LAST_DOT + 1;
`ifdef PPU_TIMING_PAL_EN
  localparam bit PAL = 1'b1;
`else
  localparam bit PAL = 1'b0;
`endif

  logic m_clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_full_n = 1'b0;
  always #5 m_clk = ~m_clk;

  ppu_timing_if sif();
  ppu_timing_if fif();

  ppu_timing #(
    .LAST_DOT(S_LAST), .VBLANK_LINE(S_VB), .PRE_LINE(S_PRE),
    .VISIBLE_LINES(S_VL), .VISIBLE_DOTS(S_VD)
  ) u_dut (.m_clk(m_clk), .rst_n(rst_n), .bus(sif));

  ppu_timing u_dut_full (.m_clk(m_clk), .rst_n(rst_full_n), .bus(fif));

  int n_checks = 0;
  int n_fail = 0;

  // model of the small instance: ticks since frame start plus event flags
  int m_t, m_cyc, m_last_rd;
  bit m_odd, m_vb, m_stat, m_nmi, m_fs;
  int f_t = 0;
  int tick_cnt = 0;
  int phase = 0;
  int flen[$];
  int skip_visits = 0;
  bit race_watch = 0;
  int race_bad = 0;

  always @(posedge m_clk) if (rst_full_n) f_t <= f_t + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_cyc = 0; m_last_rd = -10;
    m_odd = 0; m_vb = 0; m_stat = 0; m_nmi = 1; m_fs = 0;
  endtask

  task automatic model_tick(input bit pt, input bit ct, input bit rd, input bit re, input bit ne);
    bit read, wrap;
    read  = ct & rd;
    m_nmi = !(m_vb && ne);
    m_fs  = 0;
    if (read) m_stat = m_vb;
    if (pt) begin
      wrap = (m_t == N - 1) || (!PAL && m_t == N - 2 && m_odd && re);
      if (wrap) begin m_t = 0; m_odd = !m_odd; m_fs = 1; end
      else m_t++;
      if (m_t == S_VB * W + 1 && !(read || m_last_rd == m_cyc - 1)) m_vb = 1;
      if (m_t == S_PRE * W + 1) m_vb = 0;
    end
    if (read) begin m_vb = 0; m_last_rd = m_cyc; end
    m_cyc++;
  endtask

  task automatic compare_all();
    int d, l;
    d = m_t % W; l = m_t / W;
    chk("dot", sif.dot, d);
    chk("scanline", sif.scanline, l);
    chk("visible", sif.visible, (l < S_VL && d >= 1 && d <= S_VD) ? 1 : 0);
    chk("vblank", sif.vblank, m_vb);
    chk("status_vblank", sif.status_vblank, m_stat);
    chk("nmi_n", sif.nmi_n, m_nmi);
    chk("frame_odd", sif.frame_odd, m_odd);
    chk("frame_start", sif.frame_start, m_fs);
    d = f_t % FW; l = f_t / FW;
    chk("full_dot", fif.dot, d);
    chk("full_scanline", fif.scanline, l);
    chk("full_visible", fif.visible,
        (l < VISIBLE_LINES && d >= 1 && d <= VISIBLE_DOTS) ? 1 : 0);
  endtask

  task automatic step(input bit pt, input bit ct, input bit rd);
    sif.ppu_tick = pt; sif.cpu_tick = ct; sif.status_rd = rd;
    @(posedge m_clk);
    model_tick(pt, ct, rd, sif.render_en, sif.nmi_en);
    if (pt) tick_cnt++;
    @(negedge m_clk);
    compare_all();
    if (sif.frame_start === 1'b1) begin flen.push_back(tick_cnt); tick_cnt = 0; end
    if (sif.render_en && sif.frame_odd && sif.dot == S_LAST && sif.scanline == S_PRE)
      skip_visits++;
    if (race_watch && (sif.vblank !== 1'b0 || sif.nmi_n !== 1'b1)) race_bad++;
    sif.ppu_tick = 0; sif.cpu_tick = 0; sif.status_rd = 0;
  endtask

  task automatic run1();
    bit pt, ct;
    pt = (phase % 3 == 0);
    ct = (phase == 0);
    phase = (phase + 1) % 12;
    step(pt, ct, 1'b0);
  endtask

  task automatic goto_pos(input int line, input int dot);
    int budget;
    budget = 2 * N * 3 + 50;
    while (m_t != line * W + dot && budget > 0) begin run1(); budget--; end
    if (budget == 0) chk("goto_timeout", m_t, line * W + dot);
  endtask

  task automatic run_frames(input int k);
    int budget;
    budget = k * (N * 3 + 50);
    while (flen.size() < k && budget > 0) begin run1(); budget--; end
    chk("frames_seen", flen.size(), k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.ppu_tick = 0; sif.cpu_tick = 0; sif.status_rd = 0;
    sif.render_en = 0; sif.nmi_en = 0;
    fif.ppu_tick = 1; fif.cpu_tick = 0; fif.status_rd = 0;
    fif.render_en = 0; fif.nmi_en = 0;
    model_reset();
    #12;
    chk("rst_dot", sif.dot, 0);
    chk("rst_scanline", sif.scanline, 0);
    chk("rst_visible", sif.visible, 0);
    chk("rst_vblank", sif.vblank, 0);
    chk("rst_status", sif.status_vblank, 0);
    chk("rst_nmi_n", sif.nmi_n, 1);
    chk("rst_frame_odd", sif.frame_odd, 0);
    chk("rst_frame_start", sif.frame_start, 0);
    @(negedge m_clk);
    rst_n = 1; rst_full_n = 1; sif.nmi_en = 1;

    // first tick after release lands on dot 1
    step(1, 0, 0);
    chk("first_tick_dot", sif.dot, 1);
    chk("first_tick_line", sif.scanline, 0);
    phase = 1;

    // frame lengths: two frames without rendering, then even/odd with rendering
    run_frames(1);
    chk("odd_after_f0", sif.frame_odd, 1);
    run_frames(2);
    chk("odd_after_f1", sif.frame_odd, 0);
    sif.render_en = 1;
    run_frames(4);
    chk("odd_after_f3", sif.frame_odd, 0);
    chk("len_f0", flen.size() > 0 ? flen[0] : -1, 231);
    chk("len_f1_noskip", flen.size() > 1 ? flen[1] : -1, 231);
    chk("len_f2_even", flen.size() > 2 ? flen[2] : -1, 231);
    chk("len_f3_skip", flen.size() > 3 ? flen[3] : -1, PAL ? 231 : 230);
    chk("skip_dot_unvisited", skip_visits, 0);

    // vblank set and NMI one m_clk later
    goto_pos(S_VB, 0);
    step(1, 0, 0);
    chk("vbl_set", sif.vblank, 1);
    chk("nmi_not_yet", sif.nmi_n, 1);
    step(0, 0, 0);
    chk("nmi_fall", sif.nmi_n, 0);

    // nmi_en off then on re-arms a falling edge
    goto_pos(S_VB, 5);
    sif.nmi_en = 0;
    step(0, 0, 0); step(0, 0, 0);
    chk("nmi_masked", sif.nmi_n, 1);
    sif.nmi_en = 1;
    step(0, 0, 0);
    chk("nmi_refall", sif.nmi_n, 0);

    // read clear in mid-vblank
    goto_pos(S_VB + 1, 5);
    step(0, 1, 1);
    chk("rd_status", sif.status_vblank, 1);
    chk("rd_vblank_clr", sif.vblank, 0);
    step(0, 0, 0);
    chk("rd_nmi_release", sif.nmi_n, 1);

    // race: read on the set tick itself
    goto_pos(S_VB, 0);
    step(1, 1, 1);
    chk("race_status", sif.status_vblank, 0);
    chk("race_vblank", sif.vblank, 0);
    race_watch = 1;
    goto_pos(S_PRE, 1);
    race_watch = 0;
    chk("race_hold", race_bad, 0);

    // race: read one m_clk before the set tick
    goto_pos(S_VB, 0);
    step(0, 1, 1);
    chk("race_pre_status", sif.status_vblank, 0);
    step(1, 0, 0);
    chk("race_pre_vblank", sif.vblank, 0);
    step(0, 0, 0);
    chk("race_pre_nmi", sif.nmi_n, 1);

    // pre-render clear and read-clear on the same edge
    goto_pos(0, 5);
    goto_pos(S_PRE, 0);
    chk("pre_vblank_set", sif.vblank, 1);
    step(1, 1, 1);
    chk("pre_rd_status", sif.status_vblank, 1);
    chk("pre_rd_vblank", sif.vblank, 0);

    // mid-frame asynchronous reset
    goto_pos(3, 12);
    chk("midrst_vblank_before", sif.vblank, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_dot", sif.dot, 0);
    chk("midrst_line", sif.scanline, 0);
    chk("midrst_visible", sif.visible, 0);
    chk("midrst_vblank", sif.vblank, 0);
    chk("midrst_status", sif.status_vblank, 0);
    chk("midrst_nmi_n", sif.nmi_n, 1);
    chk("midrst_frame_odd", sif.frame_odd, 0);
    chk("midrst_frame_start", sif.frame_start, 0);
    model_reset();
    tick_cnt = 0; phase = 1;
    @(negedge m_clk);
    rst_n = 1;
    step(1, 0, 0);
    chk("restart_dot", sif.dot, 1);
    chk("restart_line", sif.scanline, 0);
    for (int i = 0; i < 60; i++) run1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
